// File: rtl/battleship_game.sv
// Two-player Battleship referee: fleet placement, shot validation and result reporting.
// Optional macro BATTLESHIP_EXTRA_TURN_EN: a hit or sunk result keeps the turn with the shooter.
module battleship_game #(
    parameter int unsigned BOARD_SIZE = 10
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic        read,
    input  logic        player,
    input  logic        direction,
    input  logic [3:0]  row,
    input  logic [3:0]  col,
    output logic [11:0] data_out,
    output logic        data_ready
);
    localparam int unsigned CELLS = BOARD_SIZE * BOARD_SIZE;
    localparam int unsigned IW    = $clog2(CELLS);

    localparam logic [2:0] C_PLACED  = 3'b001;
    localparam logic [2:0] C_PERR    = 3'b010;
    localparam logic [2:0] C_MISS    = 3'b011;
    localparam logic [2:0] C_HIT     = 3'b100;
    localparam logic [2:0] C_SUNK    = 3'b101;
    localparam logic [2:0] C_WIN     = 3'b110;
    localparam logic [2:0] C_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {PLACE_P0, PLACE_P1, PLAY, OVER} state_e;

    function automatic int unsigned ship_len(input logic [2:0] id);
        case (id)
            3'd0:    return 5;
            3'd1:    return 4;
            3'd2,
            3'd3:    return 3;
            default: return 2;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [2:0]        ship_idx_q, ship_idx_d;
    logic              turn_q, turn_d;
    logic [CELLS-1:0]  occ_q [2], occ_d [2];
    logic [CELLS-1:0]  shot_q [2], shot_d [2];
    logic [2:0]        sid_q [2][CELLS], sid_d [2][CELLS];
    logic [2:0]        hits_q [2][5], hits_d [2][5];
    logic [4:0]        total_q [2], total_d [2];
    logic              cmd_vld_q, cmd_vld_d;
    logic              cmd_player_q, cmd_player_d;
    logic              cmd_dir_q, cmd_dir_d;
    logic [3:0]        cmd_row_q, cmd_row_d, cmd_col_q, cmd_col_d;
    logic [11:0]       data_out_q, data_out_d;
    logic              data_ready_q, data_ready_d;

    logic [2:0]        code;
    logic              bad, tgt;
    int unsigned       r, c;
    logic [IW-1:0]     tidx;
    logic [2:0]        sid, nhits;
    logic [4:0]        ntotal;

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state_q      <= PLACE_P0;
            ship_idx_q   <= '0;
            turn_q       <= 1'b0;
            occ_q        <= '{default: '0};
            shot_q       <= '{default: '0};
            sid_q        <= '{default: '0};
            hits_q       <= '{default: '0};
            total_q      <= '{default: '0};
            cmd_vld_q    <= 1'b0;
            cmd_player_q <= 1'b0;
            cmd_dir_q    <= 1'b0;
            cmd_row_q    <= '0;
            cmd_col_q    <= '0;
            data_out_q   <= '0;
            data_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ship_idx_q   <= ship_idx_d;
            turn_q       <= turn_d;
            occ_q        <= occ_d;
            shot_q       <= shot_d;
            sid_q        <= sid_d;
            hits_q       <= hits_d;
            total_q      <= total_d;
            cmd_vld_q    <= cmd_vld_d;
            cmd_player_q <= cmd_player_d;
            cmd_dir_q    <= cmd_dir_d;
            cmd_row_q    <= cmd_row_d;
            cmd_col_q    <= cmd_col_d;
            data_out_q   <= data_out_d;
            data_ready_q <= data_ready_d;
        end
    end

    // Commands are captured in one stage and evaluated in the next, giving two-edge latency.
    always_comb begin
        cmd_vld_d    = read;
        cmd_player_d = player;
        cmd_dir_d    = direction;
        cmd_row_d    = row;
        cmd_col_d    = col;
        state_d      = state_q;
        ship_idx_d   = ship_idx_q;
        turn_d       = turn_q;
        occ_d        = occ_q;
        shot_d       = shot_q;
        sid_d        = sid_q;
        hits_d       = hits_q;
        total_d      = total_q;
        data_ready_d = cmd_vld_q;
        data_out_d   = data_out_q;
        code         = C_ILLEGAL;
        bad          = 1'b0;
        tgt          = ~cmd_player_q;
        r            = 0;
        c            = 0;
        tidx         = '0;
        sid          = '0;
        nhits        = '0;
        ntotal       = '0;
        if (cmd_vld_q) begin
            case (state_q)
                PLACE_P0, PLACE_P1: begin
                    if (cmd_player_q == (state_q == PLACE_P1)) begin
                        for (int unsigned k = 0; k < 5; k++) begin
                            r = 32'(cmd_row_q) + (cmd_dir_q ? k : 0);
                            c = 32'(cmd_col_q) + (cmd_dir_q ? 0 : k);
                            if (k < ship_len(ship_idx_q)) begin
                                if (r >= BOARD_SIZE || c >= BOARD_SIZE)
                                    bad = 1'b1;
                                else if (occ_q[cmd_player_q][IW'(r * BOARD_SIZE + c)])
                                    bad = 1'b1;
                            end
                        end
                        if (bad) begin
                            code = C_PERR;
                        end else begin
                            code = C_PLACED;
                            for (int unsigned k = 0; k < 5; k++) begin
                                r = 32'(cmd_row_q) + (cmd_dir_q ? k : 0);
                                c = 32'(cmd_col_q) + (cmd_dir_q ? 0 : k);
                                if (k < ship_len(ship_idx_q)) begin
                                    tidx = IW'(r * BOARD_SIZE + c);
                                    occ_d[cmd_player_q][tidx] = 1'b1;
                                    sid_d[cmd_player_q][tidx] = ship_idx_q;
                                end
                            end
                            if (ship_idx_q == 3'd4) begin
                                ship_idx_d = '0;
                                turn_d     = 1'b0;
                                state_d    = (state_q == PLACE_P0) ? PLACE_P1 : PLAY;
                            end else begin
                                ship_idx_d = ship_idx_q + 3'd1;
                            end
                        end
                    end
                end
                PLAY: begin
                    if (cmd_player_q == turn_q && 32'(cmd_row_q) < BOARD_SIZE &&
                        32'(cmd_col_q) < BOARD_SIZE) begin
                        tidx = IW'(32'(cmd_row_q) * BOARD_SIZE + 32'(cmd_col_q));
                        if (!shot_q[tgt][tidx]) begin
                            shot_d[tgt][tidx] = 1'b1;
                            if (!occ_q[tgt][tidx]) begin
                                code   = C_MISS;
                                turn_d = ~turn_q;
                            end else begin
                                sid              = sid_q[tgt][tidx];
                                nhits            = hits_q[tgt][sid] + 3'd1;
                                hits_d[tgt][sid] = nhits;
                                ntotal           = total_q[tgt] + 5'd1;
                                total_d[tgt]     = ntotal;
                                if (ntotal == 5'd17) begin
                                    code    = C_WIN;
                                    state_d = OVER;
                                end else begin
                                    code = (32'(nhits) == ship_len(sid)) ? C_SUNK : C_HIT;
`ifdef BATTLESHIP_EXTRA_TURN_EN
                                    turn_d = turn_q;
`else
                                    turn_d = ~turn_q;
`endif
                                end
                            end
                        end
                    end
                end
                default: code = C_ILLEGAL;
            endcase
            data_out_d = {code, cmd_player_q, cmd_row_q, cmd_col_q};
        end
    end

    always_comb begin
        data_out   = data_out_q;
        data_ready = data_ready_q;
    end
endmodule

// File: tb/tb_battleship_game.sv
// Directed bench for battleship_game: placement, firing, win, OVER and mid-game reset.
module tb_battleship_game;
    logic        ph1, reset, read, player, direction;
    logic [3:0]  row, col;
    logic [11:0] data_out;
    logic        data_ready;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [11:0] last_exp = '0;
    logic [11:0] win_seq [14];
    logic [11:0] e;
    logic [3:0]  mr, mc;

    battleship_game #(.BOARD_SIZE(10)) dut (
        .ph1       (ph1),
        .reset     (reset),
        .read      (read),
        .player    (player),
        .direction (direction),
        .row       (row),
        .col       (col),
        .data_out  (data_out),
        .data_ready(data_ready)
    );

    initial begin
        ph1 = 1'b0;
        forever #5 ph1 = ~ph1;
    end

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic p, input logic d, input logic [3:0] r, input logic [3:0] c,
                          input logic [11:0] exp, input string tag);
        @(negedge ph1);
        read = 1'b1; player = p; direction = d; row = r; col = c;
        @(posedge ph1); #1;
        read = 1'b0;
        chk({tag, "_idle"}, {11'b0, data_ready}, 12'd0);
        chk({tag, "_hold"}, data_out, last_exp);
        @(posedge ph1); #1;
        chk({tag, "_rdy"}, {11'b0, data_ready}, 12'd1);
        chk(tag, data_out, exp);
        last_exp = exp;
    endtask

    initial begin
        win_seq = '{12'h801, 12'h802, 12'h803, 12'hA04, 12'h820, 12'h821, 12'h822,
                    12'hA23, 12'h840, 12'h841, 12'hA42, 12'h860, 12'h861, 12'hC62};
        reset = 1'b1; read = 1'b0; player = 1'b0; direction = 1'b0; row = '0; col = '0;
        #2 reset = 1'b0;
        repeat (3) @(posedge ph1);
        #1;
        chk("rst_data", data_out, 12'h000);
        chk("rst_rdy", {11'b0, data_ready}, 12'd0);
        @(negedge ph1) reset = 1'b1;

        // P0 fleet, with overlap, out-of-bounds and wrong-player probes
        do_cmd(0, 0, 4'd0, 4'd0, 12'h200, "p0_s0");
        do_cmd(0, 1, 4'd0, 4'd2, 12'h402, "p0_overlap");
        do_cmd(0, 0, 4'd0, 4'd6, 12'h206, "p0_s1_edge");
        do_cmd(0, 0, 4'd5, 4'd8, 12'h458, "p0_oob");
        do_cmd(1, 0, 4'd0, 4'd0, 12'hF00, "p1_in_p0");
        do_cmd(0, 0, 4'd2, 4'd0, 12'h220, "p0_s2");
        do_cmd(0, 0, 4'd4, 4'd0, 12'h240, "p0_s3");
        do_cmd(0, 1, 4'd6, 4'd0, 12'h260, "p0_s4");
        do_cmd(0, 0, 4'd8, 4'd8, 12'hE88, "p0_in_p1");

        // back-to-back reads on consecutive edges
        @(negedge ph1);
        read = 1'b1; player = 1'b1; direction = 1'b0; row = 4'd0; col = 4'd0;
        @(posedge ph1); #1;
        row = 4'd2;
        @(posedge ph1); #1;
        read = 1'b0;
        chk("b2b_a_rdy", {11'b0, data_ready}, 12'd1);
        chk("b2b_a", data_out, 12'h300);
        @(posedge ph1); #1;
        chk("b2b_b_rdy", {11'b0, data_ready}, 12'd1);
        chk("b2b_b", data_out, 12'h320);
        last_exp = 12'h320;

        do_cmd(1, 0, 4'd4, 4'd0, 12'h340, "p1_s2");
        do_cmd(1, 0, 4'd6, 4'd0, 12'h360, "p1_s3");
        do_cmd(1, 1, 4'd9, 4'd0, 12'h590, "p1_vert_oob");
        do_cmd(1, 1, 4'd8, 4'd0, 12'h380, "p1_s4");

        // play
        do_cmd(1, 0, 4'd5, 4'd5, 12'hF55, "p1_first");
        do_cmd(0, 0, 4'd0, 4'd0, 12'h800, "p0_hit00");
`ifdef BATTLESHIP_EXTRA_TURN_EN
        do_cmd(0, 0, 4'd8, 4'd0, 12'h880, "xt_again");
        do_cmd(0, 0, 4'd7, 4'd9, 12'h679, "xt_miss");
        do_cmd(0, 0, 4'd9, 4'd0, 12'hE90, "xt_after_miss");
        do_cmd(1, 0, 4'd9, 4'd9, 12'h799, "p1_miss99");
        do_cmd(0, 0, 4'd9, 4'd0, 12'hA90, "p0_sink4");
        do_cmd(0, 0, 4'd9, 4'd0, 12'hE90, "p0_repeat");
`else
        do_cmd(1, 0, 4'd9, 4'd9, 12'h799, "p1_miss99");
        do_cmd(1, 0, 4'd9, 4'd8, 12'hF98, "p1_twice");
        do_cmd(0, 0, 4'd10, 4'd0, 12'hEA0, "p0_row_oob");
        do_cmd(0, 0, 4'd8, 4'd0, 12'h880, "p0_hit80");
        do_cmd(1, 0, 4'd9, 4'd8, 12'h798, "p1_miss98");
        do_cmd(0, 0, 4'd9, 4'd0, 12'hA90, "p0_sink4");
        do_cmd(1, 0, 4'd9, 4'd7, 12'h797, "p1_miss97");
        do_cmd(0, 0, 4'd9, 4'd0, 12'hE90, "p0_repeat");
`endif
        for (int i = 0; i < 14; i++) begin
            e = win_seq[i];
            do_cmd(0, 0, e[7:4], e[3:0], e, "win_run");
`ifndef BATTLESHIP_EXTRA_TURN_EN
            if (i < 13) begin
                mr = (i < 7) ? 4'd9 : 4'd8;
                mc = (i < 7) ? 4'(6 - i) : 4'(16 - i);
                do_cmd(1, 0, mr, mc, {3'b011, 1'b1, mr, mc}, "p1_filler");
            end
`endif
        end
        do_cmd(1, 0, 4'd0, 4'd0, 12'hF00, "over_p1");
        do_cmd(0, 0, 4'd5, 4'd5, 12'hE55, "over_p0");

        // reset with a result pending
        @(negedge ph1);
        read = 1'b1; player = 1'b0; direction = 1'b0; row = 4'd0; col = 4'd0;
        @(posedge ph1); #1;
        read = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_data", data_out, 12'h000);
        chk("midrst_rdy", {11'b0, data_ready}, 12'd0);
        @(posedge ph1); #1;
        chk("midrst_drop", {11'b0, data_ready}, 12'd0);
        @(negedge ph1) reset = 1'b1;
        last_exp = '0;
        do_cmd(0, 0, 4'd0, 4'd0, 12'h200, "re_s0");
        do_cmd(0, 1, 4'd0, 4'd2, 12'h402, "re_overlap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
